// File: rtl/leiwand_rv32_wb_uart_tx_pkg.sv
// Shared register map, STATUS layout and transmitter state encoding for the Wishbone UART TX.
package leiwand_rv32_wb_uart_tx_pkg;

   // Register offsets, decoded from addr[3:2]; the other two offsets read as zero
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   // write_size carries 1, 2 or 4, so three bits are enough
   localparam int unsigned WRITE_SIZE_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // STATUS register layout, LSB is bit 0 (full)
   typedef struct packed {
      logic [3:0] count;
      logic       overflow;
      logic       busy;
      logic       empty;
      logic       full;
   } status_t;

   // FIFO occupancy as shown in STATUS, clipped to the 4-bit field
   function automatic logic [3:0] sat_count(input int unsigned c);
      return (c > 32'd15) ? 4'hF : 4'(c);
   endfunction

endpackage

// File: rtl/leiwand_rv32_fifo.sv
// Synchronous byte FIFO; pushes into a full FIFO are dropped, pops of an empty FIFO are ignored.
module leiwand_rv32_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_c, do_pop_c;

   assign full_c    = (count_q == CW'(DEPTH));
   assign empty_c   = (count_q == '0);
   // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always lost
   assign do_push_c = push_i && !full_c;
   assign do_pop_c  = pop_i && !empty_c;
   assign rdata_c   = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Wishbone-attached UART transmitter: TXDATA/STATUS registers, byte FIFO and 8N1 serialiser.
module leiwand_rv32_wb_uart_tx
   import leiwand_rv32_wb_uart_tx_pkg::*;
#(
   parameter int unsigned MEM_WIDTH    = 32,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [MEM_WIDTH-1:0]    addr,
   input  logic [MEM_WIDTH-1:0]    data_in,
   output logic [MEM_WIDTH-1:0]    data_out,
   input  logic                    we,
   input  logic                    stb,
   output logic                    ack,
   input  logic                    cyc,
   output logic                    stall,
   input  logic [WRITE_SIZE_W-1:0] write_size,
   output logic                    tx
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   logic                 accept_c, push_c, clr_ovf_c, pop_c, baud_end_c;
   logic [1:0]           reg_sel_c;
   logic                 fifo_full_c, fifo_empty_c;
   logic [7:0]           fifo_head_c;
   logic [CNT_W-1:0]     fifo_count_c;
   status_t              status_c;
   logic [MEM_WIDTH-1:0] rdata_c;

   logic                 ack_q;
   logic [MEM_WIDTH-1:0] data_out_q;
   logic                 ovf_q, ovf_d;
   tx_state_e            state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;

   // Byte size only matters for wider registers; only addr[3:2] and the low data byte are used
   logic unused_c;
   assign unused_c = ^{addr[MEM_WIDTH-1:4], addr[1:0], data_in[MEM_WIDTH-1:8], write_size};

   assign accept_c  = stb && cyc;
   assign reg_sel_c = addr[3:2];
   assign push_c    = accept_c && we && (reg_sel_c == REG_TXDATA);
   assign clr_ovf_c = accept_c && we && (reg_sel_c == REG_STATUS);

   leiwand_rv32_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_c),
      .wdata_i (data_in[7:0]),
      .pop_i   (pop_c),
      .rdata_c (fifo_head_c),
      .full_c  (fifo_full_c),
      .empty_c (fifo_empty_c),
      .count_o (fifo_count_c)
   );

   // STATUS snapshot taken before any same-cycle push lands
   always_comb begin
      status_c.count    = sat_count(32'(fifo_count_c));
      status_c.overflow = ovf_q;
      status_c.busy     = (state_q != ST_IDLE);
      status_c.empty    = fifo_empty_c;
      status_c.full     = fifo_full_c;
      rdata_c           = (reg_sel_c == REG_STATUS) ? MEM_WIDTH'(status_c) : '0;
   end

   // Sticky overflow: set by a lost push, cleared by any STATUS write
   always_comb begin
      ovf_d = ovf_q;
      if (clr_ovf_c)             ovf_d = 1'b0;
      if (push_c && fifo_full_c) ovf_d = 1'b1;
   end

   // Bus response: one-cycle ack, read data only while acknowledging a read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_q      <= 1'b0;
         data_out_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         ack_q      <= accept_c;
         data_out_q <= (accept_c && !we) ? rdata_c : '0;
         ovf_q      <= ovf_d;
      end
   end

   assign baud_end_c = (baud_q == BAUD_LAST);

   // Serialiser next state; tx_d is the line level for the coming cycle
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty_c) begin
               pop_c   = 1'b1;
               shift_d = fifo_head_c;
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (baud_end_c) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_end_c) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_end_c) begin
               baud_d = '0;
               // Chain straight into the next start bit when more bytes wait
               if (!fifo_empty_c) begin
                  pop_c   = 1'b1;
                  shift_d = fifo_head_c;
                  bit_d   = '0;
                  state_d = ST_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // Serialiser state register; reset aborts any frame with the line high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign ack      = ack_q;
   assign data_out = data_out_q;
   assign stall    = 1'b0;
   assign tx       = tx_q;

endmodule

// File: tb/tb_leiwand_rv32_wb_uart_tx.sv
// Self-checking bench for the Wishbone UART TX: register table, frame decoder, random bursts.
module tb_leiwand_rv32_wb_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned MW    = 32;
   localparam int          FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          reset;
   logic [MW-1:0] addr, data_in, data_out;
   logic          we, stb, cyc, ack, stall, tx;
   logic [2:0]    write_size;

   leiwand_rv32_wb_uart_tx #(
      .MEM_WIDTH    (MW),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .we         (we),
      .stb        (stb),
      .ack        (ack),
      .cyc        (cyc),
      .stall      (stall),
      .write_size (write_size),
      .tx         (tx)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];      // bytes the line is expected to carry, in order
   bit         mon_en = 1'b0;
   int         mon_pos = -1;
   bit         mon_ok;
   logic [7:0] mon_sh;
   int         cyc_n = 0;
   int         start_last = -1;
   int         start_prev = -1;

   always @(posedge clk) cyc_n++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Line decoder: 1 start bit low, 8 data bits LSB first, 1 stop bit high, CPB clocks each
   always @(negedge clk) begin
      if (reset || !mon_en) begin
         mon_pos = -1;
      end else begin
         if (mon_pos < 0) begin
            if (tx === 1'b0) begin
               mon_pos    = 0;
               mon_ok     = 1'b1;
               start_prev = start_last;
               start_last = cyc_n;
            end
         end else begin
            mon_pos++;
         end
         if (mon_pos >= 0) begin
            if (mon_pos < CPB) begin
               if (tx !== 1'b0) mon_ok = 1'b0;
            end else if (mon_pos < 9 * CPB) begin
               int b;
               b = (mon_pos - CPB) / CPB;
               if ((mon_pos - CPB) % CPB == 0) mon_sh[b] = tx;
               else if (tx !== mon_sh[b]) mon_ok = 1'b0;
            end else begin
               if (tx !== 1'b1) mon_ok = 1'b0;
            end
            if (mon_pos == FRAME - 1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame unexpected byte actual=0x%0h expected=none", mon_sh);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  check("frame", {23'd0, mon_ok, mon_sh}, {23'd0, 1'b1, e});
               end
               mon_pos = -1;
            end
         end
      end
   end

   // One bus cycle: drive at negedge, accepted at posedge, response sampled at next negedge
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                       input logic s, input logic c, output logic a_o, output logic [31:0] d_o);
      we = w; addr = a; data_in = d; write_size = sz; stb = s; cyc = c;
      @(posedge clk);
      #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(negedge clk);
      a_o = ack;
      d_o = data_out;
   endtask

   task automatic bus_write(input string name, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      logic k;
      logic [31:0] r;
      xfer(1'b1, a, d, sz, 1'b1, 1'b1, k, r);
      check({name, "_ack"}, 32'(k), 32'd1);
   endtask

   task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic k;
      logic [31:0] r;
      xfer(1'b0, a, 32'd0, 3'd4, 1'b1, 1'b1, k, r);
      check({name, "_ack"}, 32'(k), 32'd1);
      check({name, "_data"}, r, exp);
   endtask

   // Poll STATUS until idle and empty, then confirm every expected byte came out
   task automatic wait_idle(input string name, input int budget);
      logic k;
      logic [31:0] r;
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         xfer(1'b0, 32'h4, 32'd0, 3'd4, 1'b1, 1'b1, k, r);
         if (k === 1'b1 && r === 32'h2) done = 1'b1;
      end
      check({name, "_idle"}, 32'(done), 32'd1);
      repeat (2) @(negedge clk);
      check({name, "_drain"}, exp_q.size(), 32'd0);
   endtask

   typedef struct {
      logic        s;
      logic        c;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  sz;
      logic        exp_ack;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vt[12];

   initial begin
      #400000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        k1, k2, k3;
      logic [31:0] r;
      logic [7:0]  b;
      int          errs, c0, lows, n, gap, op;
      bit          found;
      logic [2:0]  sizes[3];

      sizes[0] = 3'd1; sizes[1] = 3'd2; sizes[2] = 3'd4;
      reset = 1'b1; we = 1'b0; stb = 1'b0; cyc = 1'b0;
      addr = '0; data_in = '0; write_size = 3'd1;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dout", data_out, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Register map table
      vt[0]  = '{1, 1, 0, 32'h4,        32'h0,  3'd4, 1, 32'h2};
      vt[1]  = '{1, 1, 0, 32'h0,        32'h0,  3'd4, 1, 32'h0};
      vt[2]  = '{1, 1, 0, 32'h8,        32'h0,  3'd4, 1, 32'h0};
      vt[3]  = '{1, 1, 0, 32'hC,        32'h0,  3'd4, 1, 32'h0};
      vt[4]  = '{1, 1, 1, 32'h8,        32'hAA, 3'd4, 1, 32'h0};
      vt[5]  = '{1, 1, 1, 32'hC,        32'h55, 3'd1, 1, 32'h0};
      vt[6]  = '{0, 1, 0, 32'h4,        32'h0,  3'd4, 0, 32'h0};
      vt[7]  = '{1, 0, 0, 32'h4,        32'h0,  3'd4, 0, 32'h0};
      vt[8]  = '{0, 0, 1, 32'h0,        32'h77, 3'd1, 0, 32'h0};
      vt[9]  = '{1, 1, 1, 32'h4,        32'h0,  3'd4, 1, 32'h0};
      vt[10] = '{1, 1, 0, 32'hFFFFFFF4, 32'h0,  3'd4, 1, 32'h2};
      vt[11] = '{1, 1, 0, 32'h4,        32'h0,  3'd4, 1, 32'h2};
      for (int i = 0; i < 12; i++) begin
         xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].sz, vt[i].s, vt[i].c, k1, r);
         check($sformatf("vec%0d_ack", i), 32'(k1), 32'(vt[i].exp_ack));
         check($sformatf("vec%0d_dout", i), r, vt[i].exp_dout);
         check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      end
      repeat (4) @(negedge clk);
      check("table_tx_idle", 32'(tx), 32'd1);

      // Single byte 0x55: latency and exact line waveform
      exp_q.push_back(8'h55);
      bus_write("w55", 32'h0, 32'h55, 3'd1);
      found = 1'b0;
      for (int i = 0; i < 2 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      check("w55_latency", 32'(found), 32'd1);
      b = 8'h55;
      errs = 0;
      for (int kk = 0; kk < FRAME; kk++) begin
         logic e;
         if (kk > 0) @(negedge clk);
         if (kk < CPB)          e = 1'b0;
         else if (kk < 9 * CPB) e = b[(kk - CPB) / CPB];
         else                   e = 1'b1;
         if (tx !== e) errs++;
      end
      check("w55_wave_errs", errs, 32'd0);
      repeat (CPB) @(negedge clk);
      check("w55_idle_high", 32'(tx), 32'd1);
      wait_idle("w55", 200);

      // Back-to-back writes: consecutive acks, contiguous frames
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      we = 1'b1; addr = 32'h0; data_in = 32'hA5; write_size = 3'd1; stb = 1'b1; cyc = 1'b1;
      @(posedge clk);
      #1 data_in = 32'h3C;
      @(negedge clk) k1 = ack;
      @(posedge clk);
      #1 begin stb = 1'b0; cyc = 1'b0; we = 1'b0; end
      @(negedge clk) k2 = ack;
      @(negedge clk) k3 = ack;
      check("b2b_ack1", 32'(k1), 32'd1);
      check("b2b_ack2", 32'(k2), 32'd1);
      check("b2b_ack_end", 32'(k3), 32'd0);
      wait_idle("b2b", 300);
      check("b2b_gap", start_last - start_prev, FRAME);
      bus_read("b2b_status", 32'h4, 32'h2);

      // Half-word write sends only the low byte
      exp_q.push_back(8'h34);
      bus_write("half", 32'h0, 32'h1234, 3'd2);
      wait_idle("half", 200);

      // Overflow: one byte in flight, then ten writes into an 8-deep FIFO
      exp_q.push_back(8'h81);
      bus_write("ovf_first", 32'h0, 32'h81, 3'd1);
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom);
         if (i < DEPTH) exp_q.push_back(b);
         bus_write("ovf_fill", 32'h0, {24'($urandom), b}, 3'd4);
      end
      bus_read("ovf_status", 32'h4, 32'h8D);
      bus_write("ovf_clear", 32'h4, 32'h0, 3'd4);
      bus_read("ovf_cleared", 32'h4, 32'h85);
      wait_idle("ovf", 1000);

      // Random bursts with interleaved ignored accesses
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 9);
         for (int j = 0; j < n; j++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               op = $urandom_range(0, 3);
               case (op)
                  0: bus_read("rnd_rd0", 32'h0, 32'h0);
                  1: bus_read("rnd_rd8", 32'h8, 32'h0);
                  2: bus_write("rnd_wrC", 32'hC, $urandom, 3'd4);
                  default: @(negedge clk);
               endcase
            end
            r = $urandom;
            exp_q.push_back(r[7:0]);
            bus_write("rnd_tx", 32'h0, r, sizes[$urandom_range(0, 2)]);
         end
         wait_idle("rnd", 2000);
      end

      // Reset during data bit 3 with three bytes queued
      mon_en = 1'b0;
      bus_write("rst_first", 32'h0, 32'hF0, 3'd1);
      found = 1'b0;
      for (int i = 0; i < 2 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      check("rst_frame_start", 32'(found), 32'd1);
      c0 = cyc_n;
      bus_write("rst_q1", 32'h0, 32'h11, 3'd1);
      bus_write("rst_q2", 32'h0, 32'h22, 3'd1);
      bus_write("rst_q3", 32'h0, 32'h33, 3'd1);
      bus_read("rst_pre_status", 32'h4, 32'h34);
      for (int i = 0; i < 40 && cyc_n < c0 + CPB + 3 * CPB + 1; i++) @(negedge clk);
      check("rst_pre_tx", 32'(tx), 32'd0);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_tx", 32'(tx), 32'd1);
      check("rst_mid_ack", 32'(ack), 32'd0);
      check("rst_mid_dout", data_out, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus_read("rst_post_status", 32'h4, 32'h2);
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("rst_post_quiet", lows, 32'd0);
      mon_en = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/leiwand_rv32_wb_uart_tx.md
LEIWAND_RV32_WB_UART_TX -- requirements
Module: leiwand_rv32_wb_uart_tx

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32, bus data/address width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX byte FIFO entries (power of 2).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port addr  input  MEM_WIDTH  bus address; only addr[3:2] decoded.
REQ-007 SHALL have port data_in  input  MEM_WIDTH  write data from initiator.
REQ-008 SHALL have port data_out  output  MEM_WIDTH  read data to initiator.
REQ-009 SHALL have port we  input  1  write enable.
REQ-010 SHALL have port stb  input  1  strobe, already gated by external address decode.
REQ-011 SHALL have port ack  output  1  transfer acknowledge.
REQ-012 SHALL have port cyc  input  1  bus cycle active.
REQ-013 SHALL have port stall  output  1  responder stall.
REQ-014 SHALL have port write_size  input  HIGH_BIT_TO_FIT(4)+1  write size in bytes (1/2/4).
REQ-015 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-016 SHALL accept a request when stb&&cyc; stall SHALL be constant 0.
REQ-017 SHALL assert ack for exactly one cycle, the cycle after acceptance; back-to-back requests SHALL get back-to-back acks.
REQ-018 SHALL drive data_out, ack and stall to 0 whenever not acknowledging (outputs are OR-combined on the shared bus).
REQ-019 Offset 0x0 TXDATA: write pushes data_in[7:0] for any write_size; read returns 0.
REQ-020 Offset 0x4 STATUS read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[7:4] FIFO count (saturating at 15), others 0; any write clears overflow.
REQ-021 Offsets 0x8, 0xC: reads return 0, writes ignored, still acked.
REQ-022 Push when full SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-023 Simultaneous push (not full) and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO not empty, popping head into shift register that cycle.
REQ-025 START drives tx=0 for CLKS_PER_BIT cycles; DATA shifts 8 bits LSB first, CLKS_PER_BIT each; STOP drives tx=1 for CLKS_PER_BIT cycles.
REQ-026 STOP end -> START directly if FIFO not empty (no idle gap), else IDLE.
REQ-027 Write to TXDATA with empty FIFO and IDLE SHALL make tx fall no later than 2 cycles after acceptance.
REQ-028 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reload on every bit boundary; frame = 10*CLKS_PER_BIT cycles.
REQ-029 STATUS read in the same cycle as a TXDATA push SHALL reflect pre-push state.

Reset
REQ-030 Reset SHALL asynchronously force tx=1, ack=0, stall=0, data_out=0, FSM=IDLE, FIFO empty, overflow=0, counters 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately (tx high) and discard queued bytes.

Structure
REQ-032 Register offsets, STATUS bit positions and FSM state encodings SHALL live in leiwand_rv32_constants.v.
REQ-033 The FIFO SHALL be a sub-module leiwand_rv32_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-034 Write 0x55 to 0x0 -> ack next cycle; tx = 0,1,0,1,0,1,0,1,0,1 for 4 clocks each (40 clocks), then idle high.
REQ-035 Write 0xA5, 0x3C back-to-back -> two acks consecutive; frames contiguous, 80 clocks, no idle gap; STATUS then reads 0x02.
REQ-036 Write 10 bytes while busy -> STATUS reads full=1, overflow=1, count=8; write 0 to 0x4 -> overflow=0.
REQ-037 Read 0x8 and 0xC -> ack with data_out 0; with stb=0 -> ack=0, data_out=0 every cycle.
REQ-038 Assert reset during DATA bit 3 of a frame with 3 queued -> tx=1 same cycle, STATUS afterward 0x02.
REQ-039 Half-word write 0x1234 to 0x0 -> byte 0x34 transmitted.
